id_ex_reg: RTL

ID/EX pipeline register with load-use interlock. It captures the decoded instruction and the two forwarded operand values produced by the ID-stage bypass muxes, and presents them to the EX stage one cycle later. It detects a load in EX whose destination is a source of the instruction in ID. In that case it inserts a one-cycle bubble into EX and requests the upstream stages to hold. It also honours the global stall and flush.

---
 rtl/id_ex_reg_pkg.sv | 36 +++
 rtl/id_ex_reg_load_use_detect.sv | 27 ++
 rtl/id_ex_reg.sv | 109 ++++++++++
 3 files changed

// File: rtl/id_ex_reg_pkg.sv
// Shared constants and types for the ID/EX pipeline register.
// Memory access codes match the MEM_ACCESS_TYPE_* values used across the core.
package id_ex_reg_pkg;

  typedef enum logic [1:0] {
    MEM_ACCESS_TYPE_NONE = 2'b00,
    MEM_ACCESS_TYPE_R2R  = 2'b01,
    MEM_ACCESS_TYPE_R2M  = 2'b10,
    MEM_ACCESS_TYPE_M2R  = 2'b11
  } mem_access_e;

  localparam int unsigned ALU_OP_NOP     = 0;
  localparam logic [15:0] BUBBLE_CNT_MAX = 16'hFFFF;

  // alu_op is carried separately because its width is a module parameter
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic [4:0]  dest_addr;
    mem_access_e access_type;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '{
    valid:       1'b0,
    pc:          32'd0,
    op1:         32'd0,
    op2:         32'd0,
    imm:         32'd0,
    dest_addr:   5'd0,
    access_type: MEM_ACCESS_TYPE_NONE
  };

endpackage

// File: rtl/id_ex_reg_load_use_detect.sv
// Combinational load-use hazard detect: a load in EX whose destination is read
// by the instruction in ID. Register 0 is never a hazard.
module load_use_detect
  import id_ex_reg_pkg::*;
(
  input  logic        ex_valid,
  input  mem_access_e ex_access_type,
  input  logic [4:0]  ex_dest_addr,
  input  logic [4:0]  id_rs_addr,
  input  logic [4:0]  id_rt_addr,
  input  logic        id_rs_used,
  input  logic        id_rt_used,
  output logic        load_use
);

  logic ex_is_load;
  logic rs_hit;
  logic rt_hit;

  always_comb begin
    ex_is_load = ex_valid && (ex_access_type == MEM_ACCESS_TYPE_M2R) && (ex_dest_addr != 5'd0);
    rs_hit     = id_rs_used && (id_rs_addr == ex_dest_addr);
    rt_hit     = id_rt_used && (id_rt_addr == ex_dest_addr);
    load_use   = ex_is_load && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use interlock, flush/stall priority mux
// and a saturating count of inserted load-use bubbles.
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int ALU_OP_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall_in,
  input  logic                flush,
  input  logic                id_valid,
  input  logic [31:0]         id_pc,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic [4:0]          id_rs_addr,
  input  logic [4:0]          id_rt_addr,
  input  logic                id_rs_used,
  input  logic                id_rt_used,
  input  logic [31:0]         id_op1,
  input  logic [31:0]         id_op2,
  input  logic [31:0]         id_imm,
  input  logic [4:0]          id_dest_addr,
  input  logic [1:0]          id_access_type,
  output logic                ex_valid,
  output logic [31:0]         ex_pc,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic [31:0]         ex_op1,
  output logic [31:0]         ex_op2,
  output logic [31:0]         ex_imm,
  output logic [4:0]          ex_dest_addr,
  output logic [1:0]          ex_access_type,
  output logic                stall_req,
  output logic [15:0]         bubble_cnt
);

  stage_t              ex_d, ex_q;
  logic [ALU_OP_W-1:0] alu_op_d, alu_op_q;
  logic [15:0]         bubble_cnt_d, bubble_cnt_q;
  stage_t              id_stage;
  logic                load_use;

  load_use_detect u_load_use_detect (
    .ex_valid       (ex_q.valid),
    .ex_access_type (ex_q.access_type),
    .ex_dest_addr   (ex_q.dest_addr),
    .id_rs_addr     (id_rs_addr),
    .id_rt_addr     (id_rt_addr),
    .id_rs_used     (id_rs_used),
    .id_rt_used     (id_rt_used),
    .load_use       (load_use)
  );

  always_comb begin
    id_stage.valid       = id_valid;
    id_stage.pc          = id_pc;
    id_stage.op1         = id_op1;
    id_stage.op2         = id_op2;
    id_stage.imm         = id_imm;
    id_stage.dest_addr   = id_dest_addr;
    id_stage.access_type = mem_access_e'(id_access_type);
  end

  // Priority: flush > stall_in > load_use > normal advance
  always_comb begin
    ex_d         = ex_q;
    alu_op_d     = alu_op_q;
    bubble_cnt_d = bubble_cnt_q;
    if (flush) begin
      ex_d     = STAGE_BUBBLE;
      alu_op_d = ALU_OP_W'(ALU_OP_NOP);
    end else if (!stall_in) begin
      if (load_use) begin
        ex_d     = STAGE_BUBBLE;
        alu_op_d = ALU_OP_W'(ALU_OP_NOP);
        if (bubble_cnt_q != BUBBLE_CNT_MAX) begin
          bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
      end else begin
        ex_d     = id_stage;
        alu_op_d = id_alu_op;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q         <= STAGE_BUBBLE;
      alu_op_q     <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ex_q         <= ex_d;
      alu_op_q     <= alu_op_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // A flushed ID instruction is dead, so it must not freeze the front end
  assign stall_req      = load_use && !flush;
  assign ex_valid       = ex_q.valid;
  assign ex_pc          = ex_q.pc;
  assign ex_alu_op      = alu_op_q;
  assign ex_op1         = ex_q.op1;
  assign ex_op2         = ex_q.op2;
  assign ex_imm         = ex_q.imm;
  assign ex_dest_addr   = ex_q.dest_addr;
  assign ex_access_type = ex_q.access_type;
  assign bubble_cnt     = bubble_cnt_q;

endmodule
